// File: rtl/fitbit_pkg.sv
// Shared constants for the fitbit step source.
// Mode encodings, fixed step rates and FSM states.
package fitbit_pkg;

  localparam logic [1:0] MODE_WALK   = 2'b00;
  localparam logic [1:0] MODE_JOG    = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_HYBRID = 2'b11;

  localparam logic [7:0] RATE_WALK = 8'd32;
  localparam logic [7:0] RATE_JOG  = 8'd64;
  localparam logic [7:0] RATE_RUN  = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/hybrid_rate_rom.sv
// Hybrid activity profile: step rate per elapsed second.
// Ports: seconds_i (elapsed seconds), rate_o (steps/s).
module hybrid_rate_rom
  import fitbit_pkg::*;
(
  input  logic [15:0] seconds_i,
  output logic [7:0]  rate_o
);

  always_comb begin
    rate_o = 8'd0;
    if (seconds_i < 16'd9) begin
      unique case (seconds_i[3:0])
        4'd0:    rate_o = 8'd20;
        4'd1:    rate_o = 8'd33;
        4'd2:    rate_o = 8'd66;
        4'd3:    rate_o = 8'd27;
        4'd4:    rate_o = 8'd70;
        4'd5:    rate_o = 8'd30;
        4'd6:    rate_o = 8'd19;
        4'd7:    rate_o = 8'd30;
        4'd8:    rate_o = 8'd33;
        default: rate_o = 8'd0;
      endcase
    end else if (seconds_i < 16'd73) begin
      rate_o = 8'd69;
    end else if (seconds_i < 16'd79) begin
      rate_o = 8'd34;
    end else if (seconds_i < 16'd144) begin
      rate_o = 8'd124;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Synthetic step source: exact per-second pulse rate.
// Ports: CLK, RESET, START, MODE in; OUT, SECONDS out.
module step_pulse_gen
  import fitbit_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  MODE,
  output logic        OUT,
  output logic [15:0] SECONDS
);

  localparam logic [31:0] TPS  = 32'(TICKS_PER_SEC);
  localparam logic [31:0] HALF = 32'(TICKS_PER_SEC / 2);
  localparam logic [31:0] LAST = TPS - 32'd1;

  // Rates are at most 128, so TPS >= 1024 keeps
  // every rate <= TPS/8 and pulses separated.
  if (TICKS_PER_SEC < 1024) begin : g_tps_chk
    $error("TICKS_PER_SEC must be >= 1024");
  end

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        out_q, out_d;
  logic [15:0] seconds_q, seconds_d;

  logic [7:0]  hyb_rate;
  logic [7:0]  rate;
  logic [32:0] sum;
  logic        ovf;

  hybrid_rate_rom u_rom (
    .seconds_i (seconds_q),
    .rate_o    (hyb_rate)
  );

  always_comb begin
    rate = RATE_WALK;
    unique case (mode_q)
      MODE_WALK:   rate = RATE_WALK;
      MODE_JOG:    rate = RATE_JOG;
      MODE_RUN:    rate = RATE_RUN;
      MODE_HYBRID: rate = hyb_rate;
      default:     rate = RATE_WALK;
    endcase
  end

  // 33-bit sum so the compare cannot wrap.
  assign sum = {1'b0, acc_q} + {25'd0, rate};
  assign ovf = sum >= {1'b0, TPS};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tick_cnt_d = tick_cnt_q;
    acc_d      = acc_q;
    out_d      = 1'b0;
    seconds_d  = seconds_q;
    unique case (state_q)
      ST_IDLE: begin
        tick_cnt_d = 32'd0;
        acc_d      = HALF;
        mode_d     = MODE;
        if (START) state_d = ST_RUN;
      end
      ST_RUN: begin
        tick_cnt_d = tick_cnt_q + 32'd1;
        if (ovf) begin
          acc_d = sum[31:0] - TPS;
          out_d = 1'b1;
        end else begin
          acc_d = sum[31:0];
        end
        // Half-offset restart keeps each second
        // at exactly `rate` pulses.
        if (tick_cnt_q == LAST) begin
          tick_cnt_d = 32'd0;
          acc_d      = HALF;
          mode_d     = MODE;
          if (seconds_q != 16'hFFFF)
            seconds_d = seconds_q + 16'd1;
        end
        if (!START) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (START) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_WALK;
      tick_cnt_q <= 32'd0;
      acc_q      <= HALF;
      out_q      <= 1'b0;
      seconds_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      seconds_q  <= seconds_d;
    end
  end

  assign OUT     = out_q;
  assign SECONDS = seconds_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen.
// Scoreboard of per-second pulse counts and boundaries.
module tb_step_pulse_gen;

  localparam int T = 1024;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  MODE = 2'b00;
  logic        OUT;
  logic [15:0] SECONDS;

  logic [15:0] rom_s = 16'd0;
  logic [7:0]  rom_r;

  always #5 CLK = ~CLK;

  step_pulse_gen #(.TICKS_PER_SEC(T)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .MODE    (MODE),
    .OUT     (OUT),
    .SECONDS (SECONDS)
  );

  hybrid_rate_rom u_rom_chk (
    .seconds_i (rom_s),
    .rate_o    (rom_r)
  );

  typedef struct {
    int cnt;
    int at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pulse_cnt = 0;
  logic [15:0] prev_sec = 16'd0;
  logic        prev_out = 1'b0;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int a);
    exp_t e;
    e.cnt = c;
    e.at  = a;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge CLK);
    if (OUT === 1'b1) begin
      pulse_cnt++;
      chk("pulse_gap", int'(prev_out), 0);
    end
    if (SECONDS !== prev_sec) begin
      chk("sec_step", int'(SECONDS),
          int'(prev_sec) + 1);
      chk("boundary_out", int'(OUT), 0);
      if (sb.size() == 0) begin
        chk("sb_extra_second", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("pulses_per_sec", pulse_cnt, e.cnt);
        chk("sec_cycle", cyc, e.at);
      end
      pulse_cnt = 0;
      prev_sec  = SECONDS;
    end
    prev_out = OUT;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drain(input string tag);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge CLK);
    RESET = 1'b1;
    START = 1'b0;
    MODE  = m;
    repeat (2) @(negedge CLK);
    chk("rst_out", int'(OUT), 0);
    chk("rst_sec", int'(SECONDS), 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("idle_out", int'(OUT), 0);
    START     = 1'b1;
    cyc       = 0;
    pulse_cnt = 0;
    prev_sec  = 16'd0;
    prev_out  = 1'b0;
    sb.delete();
  endtask

  task automatic rom_chk(input int s, input int r);
    rom_s = 16'(s);
    #1;
    chk($sformatf("rom_%0d", s), int'(rom_r), r);
  endtask

  initial begin
    int hv[12];
    int found;
    hv = '{20, 33, 66, 27, 70, 30,
           19, 30, 33, 69, 69, 69};

    rom_chk(0, 20);
    rom_chk(4, 70);
    rom_chk(8, 33);
    rom_chk(9, 69);
    rom_chk(72, 69);
    rom_chk(73, 34);
    rom_chk(78, 34);
    rom_chk(79, 124);
    rom_chk(143, 124);
    rom_chk(144, 0);
    rom_chk(65535, 0);

    // walk
    do_reset(2'b00);
    for (int i = 1; i <= 3; i++) push(32, i * T);
    run(3 * T + 1);
    drain("walk_done");

    // run
    do_reset(2'b10);
    for (int i = 1; i <= 2; i++) push(128, i * T);
    run(2 * T + 1);
    drain("run_done");

    // hybrid, first 12 seconds
    do_reset(2'b11);
    for (int i = 0; i < 12; i++)
      push(hv[i], (i + 1) * T);
    run(12 * T + 1);
    drain("hybrid_done");

    // mode change mid-second
    do_reset(2'b00);
    push(32, T);
    push(64, 2 * T);
    run(500);
    MODE = 2'b01;
    run(2 * T + 1 - 500);
    drain("modechg_done");

    // pause for 200 cycles
    do_reset(2'b00);
    push(32, T + 200);
    push(32, 2 * T + 200);
    run(301);
    START = 1'b0;
    run(50);
    chk("pause_out_a", int'(OUT), 0);
    chk("pause_sec_a", int'(SECONDS), 0);
    run(100);
    chk("pause_out_b", int'(OUT), 0);
    chk("pause_sec_b", int'(SECONDS), 0);
    run(50);
    START = 1'b1;
    run(2 * T + 200 + 1 - 501);
    drain("pause_done");

    // async reset between edges
    do_reset(2'b00);
    push(32, T);
    run(T + 300);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (found == 0) begin
        tick();
        if (OUT === 1'b1) found = 1;
      end
    end
    chk("wait_pulse", found, 1);
    chk("pre_rst_sec", int'(SECONDS), 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_out", int'(OUT), 0);
    chk("async_sec", int'(SECONDS), 0);
    drain("pre_async_done");
    do_reset(2'b00);
    push(32, T);
    run(T + 1);
    drain("post_async_done");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
